uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Transmit stage between the CPU byte-write port and the com_TxD pin.
//   Bytes written by the CPU are queued in a small circular FIFO. They are
//   sent as 8N1 frames (start 0, d0..d7 LSB first, stop 1). Each bit lasts
//   DIV = CLK_FREQ/BAUD clocks.
//
// Ports
//   clk50M   in   board clock, all logic on the rising edge
//   rst      in   synchronous reset, active-high
//   wr_en    in   push wr_data this cycle (dropped when full)
//   wr_data  in   byte to transmit
//   full     out  FIFO holds 2^FIFO_AW entries
//   busy     out  FIFO non-empty or a frame in progress
//   count    out  bytes queued, excluding the one being shifted out
//   overflow out  sticky, a write was attempted while full
//   com_TxD  out  registered serial line, idle high
//
// Shift FSM
//   state   | meaning
//   S_IDLE  | line high, waiting for a queued byte
//   S_START | start bit (0) for DIV clocks
//   S_DATA  | data bit bi for DIV clocks, LSB first
//   S_STOP  | stop bit (1) for DIV clocks, then next byte or idle

module uart_tx_fifo #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int FIFO_AW  = 2
) (
  input  logic               clk50M,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic               full,
  output logic               busy,
  output logic [FIFO_AW:0]   count,
  output logic               overflow,
  output logic               com_TxD
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int BC_W  = $clog2(DIV);
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [BC_W-1:0]    BC_LAST  = BC_W'(DIV - 1);
  localparam logic [BC_W-1:0]    BC_ONE   = BC_W'(1);
  localparam logic [FIFO_AW:0]   CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [BC_W-1:0]      bc_q, bc_d;
  logic [2:0]           bi_q, bi_d;
  logic [7:0]           shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           mem_q [DEPTH];

  logic                 fifo_ne;
  logic                 bc_done;
  logic                 push;
  logic                 pop;
  logic [7:0]           head;
  logic [2:0]           bi_nxt;

  assign full     = (count_q == CNT_FULL);
  assign busy     = (state_q != S_IDLE) || fifo_ne;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign com_TxD  = txd_q;

  // Pops happen only from IDLE or at the last clock of STOP, so a byte pushed
  // into an empty FIFO is never bypassed straight to the line.
  always_comb begin
    fifo_ne = (count_q != '0);
    bc_done = (bc_q == BC_LAST);
    head    = mem_q[rd_ptr_q];
    bi_nxt  = bi_q + 3'd1;
    push    = wr_en && !full;
    pop     = fifo_ne && ((state_q == S_IDLE) || ((state_q == S_STOP) && bc_done));
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    // A write while full is dropped even if a pop frees a slot this cycle.
    overflow_d = overflow_q || (wr_en && full);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    bc_d    = bc_q + BC_ONE;
    bi_d    = bi_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        bc_d  = '0;
        if (pop) begin
          shift_d = head;
          txd_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bc_done) begin
          bc_d    = '0;
          bi_d    = 3'd0;
          txd_d   = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bc_done) begin
          bc_d = '0;
          if (bi_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            bi_d  = bi_nxt;
            txd_d = shift_q[bi_nxt];
          end
        end
      end
      S_STOP: begin
        if (bc_done) begin
          bc_d = '0;
          if (pop) begin
            // Chain straight into the next start bit, no idle gap.
            shift_d = head;
            txd_d   = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        bc_d    = '0;
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bc_q       <= '0;
      bi_q       <= 3'd0;
      shift_q    <= 8'h00;
      txd_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bc_q       <= bc_d;
      bi_q       <= bi_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: resetting the pointers and count discards it.
  always_ff @(posedge clk50M) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Drives uart_tx_fifo with DIV = 10. A queue-and-frame-timer reference model
//   predicts all outputs every cycle. A line receiver decodes the frames, and
//   directed sequences cover latency, chaining, overflow, reset and wrap.
//   Inputs change 1 time unit after a rising edge; "edge E" below is the edge
//   after which wr_en is raised, so the DUT samples it at edge E+1.

module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int FIFO_AW  = 2;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int DEPTH    = 1 << FIFO_AW;
  localparam int FRAME    = 10 * DIV;

  logic               clk50M = 1'b0;
  logic               rst = 1'b1;
  logic               wr_en = 1'b0;
  logic [7:0]         wr_data = 8'h00;
  logic               full;
  logic               busy;
  logic [FIFO_AW:0]   count;
  logic               overflow;
  logic               com_TxD;

  uart_tx_fifo #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .FIFO_AW  (FIFO_AW)
  ) dut (
    .clk50M   (clk50M),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .busy     (busy),
    .count    (count),
    .overflow (overflow),
    .com_TxD  (com_TxD)
  );

  always #5 clk50M = ~clk50M;

  int cyc = 0;
  always @(posedge clk50M) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: the FIFO is a queue; a frame is a 100-cycle timer whose
  // elapsed time selects the bit on the line.
  logic [7:0] mq[$];
  logic [7:0] acc_log[$];
  int         t_left = 0;
  bit         m_ovf = 0;
  bit         mdl_live = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_full, m_pop, m_push;
  int         k;
  logic       m_txd;
  logic [6:0] m_exp, m_act;

  always @(posedge clk50M) begin
    if (rst) begin
      mq.delete();
      t_left   = 0;
      m_ovf    = 0;
      mdl_live = 1;
    end else begin
      m_full = (mq.size() == DEPTH);
      m_pop  = (mq.size() != 0) && (t_left <= 1);
      m_push = wr_en && !m_full;
      if (wr_en && m_full) m_ovf = 1;
      if (t_left > 0) t_left--;
      if (m_pop) begin
        m_byte = mq.pop_front();
        t_left = FRAME;
      end
      if (m_push) begin
        mq.push_back(wr_data);
        acc_log.push_back(wr_data);
      end
    end
    #2;
    if (mdl_live) begin
      if (t_left == 0) m_txd = 1'b1;
      else begin
        k = (FRAME - t_left) / DIV;
        if (k == 0)      m_txd = 1'b0;
        else if (k == 9) m_txd = 1'b1;
        else             m_txd = m_byte[k-1];
      end
      m_exp = {m_txd, (t_left > 0) || (mq.size() != 0), mq.size() == DEPTH, m_ovf, 3'(mq.size())};
      m_act = {com_TxD, busy, full, overflow, count};
      n_chk++;
      if (m_act !== m_exp) begin
        n_err++;
        $display("FAIL model cycle %0d: got txd/busy/full/ovf/count=%b expected %b", cyc, m_act, m_exp);
      end
    end
  end

  // Line receiver: polls each cycle for a start bit, then samples mid-bit.
  logic [7:0] rx_q[$];
  int         rx_s[$];
  int         rx_ferr = 0;

  initial begin
    int s;
    logic [7:0] b;
    forever begin
      @(posedge clk50M); #3;
      if (!rst && mdl_live && com_TxD === 1'b0) begin
        s = cyc;
        repeat (5) @(posedge clk50M);
        #3;
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(posedge clk50M);
          #3;
          b[i] = com_TxD;
        end
        repeat (10) @(posedge clk50M);
        #3;
        if (com_TxD !== 1'b1) rx_ferr++;
        rx_q.push_back(b);
        rx_s.push_back(s);
      end
    end
  end

  task automatic step();
    @(posedge clk50M);
    #1;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic clr_rx();
    rx_q.delete();
    rx_s.delete();
    acc_log.delete();
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", nm, busy, budget);
    end
  endtask

  task automatic chk_rx(input string nm, input logic [7:0] exp_q[$]);
    chk({nm, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), rx_q[i], exp_q[i]);
  endtask

  typedef struct {
    int         off;
    logic       we;
    logic [7:0] wd;
    logic       txd;
    logic       bsy;
    logic [2:0] cnt;
  } vec_t;

  vec_t t1[13];

  initial begin
    int E;
    int lows;
    int rate;
    bit saw_full;
    logic [7:0] exp_q[$];

    // offset from E | inputs driven after that edge | outputs seen after it
    t1[0]  = '{0,   1'b1, 8'h55, 1'b1, 1'b0, 3'd0};
    t1[1]  = '{1,   1'b0, 8'h00, 1'b1, 1'b1, 3'd1};
    t1[2]  = '{2,   1'b0, 8'h00, 1'b0, 1'b1, 3'd0};
    t1[3]  = '{11,  1'b0, 8'h00, 1'b0, 1'b1, 3'd0};
    t1[4]  = '{12,  1'b0, 8'h00, 1'b1, 1'b1, 3'd0};
    t1[5]  = '{21,  1'b0, 8'h00, 1'b1, 1'b1, 3'd0};
    t1[6]  = '{22,  1'b0, 8'h00, 1'b0, 1'b1, 3'd0};
    t1[7]  = '{52,  1'b0, 8'h00, 1'b1, 1'b1, 3'd0};
    t1[8]  = '{82,  1'b0, 8'h00, 1'b0, 1'b1, 3'd0};
    t1[9]  = '{91,  1'b0, 8'h00, 1'b0, 1'b1, 3'd0};
    t1[10] = '{92,  1'b0, 8'h00, 1'b1, 1'b1, 3'd0};
    t1[11] = '{101, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0};
    t1[12] = '{102, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0};

    // 1. single byte, table-driven
    do_reset();
    clr_rx();
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    E = cyc;
    for (int i = 0; i < 13; i++) begin
      step_to(E + t1[i].off);
      chk($sformatf("t1_txd_%0d", t1[i].off), com_TxD, t1[i].txd);
      chk($sformatf("t1_busy_%0d", t1[i].off), busy, t1[i].bsy);
      chk($sformatf("t1_count_%0d", t1[i].off), count, t1[i].cnt);
      wr_en = t1[i].we;
      wr_data = t1[i].wd;
    end
    exp_q = '{8'h55};
    chk_rx("t1_rx", exp_q);
    if (rx_s.size() > 0) chk("t1_start_cycle", rx_s[0], E + 2);

    // 2. back-to-back frames
    do_reset();
    clr_rx();
    E = cyc;
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    step_to(E + 201);
    chk("t2_busy_201", busy, 1);
    step();
    chk("t2_busy_202", busy, 0);
    exp_q = '{8'hA5, 8'h3C};
    chk_rx("t2_rx", exp_q);
    if (rx_s.size() == 2) begin
      chk("t2_first_start", rx_s[0], E + 2);
      chk("t2_gap", rx_s[1] - rx_s[0], FRAME);
    end

    // 3. fill and overflow
    do_reset();
    clr_rx();
    E = cyc;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        chk("t3_count_E2", count, 1);
        chk("t3_txd_E2", com_TxD, 0);
      end
      if (i == 5) begin
        chk("t3_full_E5", full, 1);
        chk("t3_count_E5", count, 4);
        chk("t3_ovf_E5", overflow, 0);
      end
      wr_en = 1'b1;
      wr_data = 8'(i + 1);
      step();
    end
    wr_en = 1'b0;
    chk("t3_ovf_E6", overflow, 1);
    chk("t3_count_E6", count, 4);
    wait_idle("t3_idle", 700);
    chk("t3_idle_cycle", cyc, E + 502);
    chk("t3_ovf_sticky", overflow, 1);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    chk_rx("t3_rx", exp_q);

    // 4. write while full on the STOP->START pop edge
    do_reset();
    clr_rx();
    E = cyc;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h11 + i);
      step();
    end
    wr_en = 1'b0;
    step_to(E + 101);
    chk("t4_count_pre", count, 4);
    chk("t4_full_pre", full, 1);
    chk("t4_ovf_pre", overflow, 0);
    wr_en = 1'b1; wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    chk("t4_count_post", count, 3);
    chk("t4_ovf_post", overflow, 1);
    chk("t4_txd_post", com_TxD, 0);
    wait_idle("t4_idle", 700);
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    chk_rx("t4_rx", exp_q);

    // 5. reset mid-frame during d3 with two bytes queued
    do_reset();
    clr_rx();
    E = cyc;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h81 + i);
      step();
    end
    wr_en = 1'b0;
    chk("t5_count_queued", count, 2);
    step_to(E + 45);
    chk("t5_txd_d3", com_TxD, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_txd", com_TxD, 1);
    chk("t5_count", count, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ovf", overflow, 0);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (com_TxD !== 1'b1) lows++;
    end
    chk("t5_line_quiet", lows, 0);
    chk("t5_busy_late", busy, 0);

    // 6. ten spaced bytes, pointer wrap
    do_reset();
    clr_rx();
    saw_full = 0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'hF0 + i);
      step();
      wr_en = 1'b0;
      saw_full |= full;
      for (int j = 0; j < 99; j++) begin
        step();
        saw_full |= full;
      end
    end
    wait_idle("t6_idle", 300);
    chk("t6_never_full", saw_full, 0);
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(8'(8'hF0 + i));
    chk_rx("t6_rx", exp_q);

    // 7. random traffic at varying write rates, checked by the model each cycle
    do_reset();
    clr_rx();
    for (int blk = 0; blk < 20; blk++) begin
      case ($urandom_range(0, 2))
        0:       rate = 1;
        1:       rate = 3;
        default: rate = 40;
      endcase
      for (int i = 0; i < 150; i++) begin
        wr_en = ($urandom_range(0, 99) < rate);
        wr_data = 8'($urandom);
        step();
      end
    end
    wr_en = 1'b0;
    wait_idle("rand_idle", 700);
    step();
    chk_rx("rand_rx", acc_log);
    chk("rx_framing", rx_ferr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
